tcb_arb: RTL and testbench

TCB_ARB -- requirements
Module: tcb_arb

---
 rtl/tcb_arb.sv | 161 ++++++++++++++++
 tb/tb_tcb_arb.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tcb_arb.sv
`default_nettype none
// ============================================================================
//  Module   : tcb_arb
//  Purpose  : Round-robin arbiter that merges PN TCB manager ports (sub_*)
//             onto a single TCB subordinate port (man_*). The grant is
//             combinational, so a request can transfer in the cycle it is
//             first raised. A stalled request is locked until it transfers.
//             Response ownership is tracked through a DLY-deep pipeline so
//             that err reaches only the port whose transfer produced it.
//  Ports    : clk, rst          - clock, synchronous active-high reset
//             sub_vld/wen       - per-port request valid / write enable [PN]
//             sub_ben/adr/wdt   - per-port byte enable, address, write data,
//                                 packed with port i in slice i
//             sub_rdt/err/rdy   - per-port read data (broadcast), error, ready
//             man_vld/wen/ben/adr/wdt - merged request to the subordinate
//             man_rdt/err/rdy   - response and ready from the subordinate
//  Revision : 1.0 - initial release
// ============================================================================
module tcb_arb #(
   parameter int AW  = 32,
   parameter int DW  = 32,
   parameter int BW  = DW/8,
   parameter int PN  = 2,
   parameter int DLY = 1
) (
   input  logic             clk,
   input  logic             rst,
   // manager devices connect here
   input  logic [PN-1:0]    sub_vld,
   input  logic [PN-1:0]    sub_wen,
   input  logic [PN*BW-1:0] sub_ben,
   input  logic [PN*AW-1:0] sub_adr,
   input  logic [PN*DW-1:0] sub_wdt,
   output logic [PN*DW-1:0] sub_rdt,
   output logic [PN-1:0]    sub_err,
   output logic [PN-1:0]    sub_rdy,
   // single subordinate device connects here
   output logic             man_vld,
   output logic             man_wen,
   output logic [BW-1:0]    man_ben,
   output logic [AW-1:0]    man_adr,
   output logic [DW-1:0]    man_wdt,
   input  logic [DW-1:0]    man_rdt,
   input  logic             man_err,
   input  logic             man_rdy
);

   // All ports share one set of width/delay parameters, so a width or delay
   // mismatch between sub and man ports cannot be expressed.
   localparam int c_IW = (PN > 1) ? $clog2(PN) : 1;

   logic [c_IW-1:0] ptr_q, ptr_d;     // last granted port
   logic            lock_q, lock_d;   // a stalled request holds the grant
   logic [c_IW-1:0] lidx_q, lidx_d;   // index held while locked
   logic [c_IW-1:0] gnt;
   logic            man_trn;
   logic            rv;
   logic [c_IW-1:0] rsel;

   // Round-robin search starting one past the last granted port.
   always_comb begin : arbitrate
      logic            found;
      logic [c_IW-1:0] idx;
      gnt   = '0;
      found = 1'b0;
      idx   = '0;
      if (lock_q) begin
         gnt = lidx_q;
      end else begin
         for (int k = 1; k <= PN; k++) begin
            idx = c_IW'((int'(ptr_q) + k) % PN);
            if (!found && sub_vld[idx]) begin
               gnt   = idx;
               found = 1'b1;
            end
         end
      end
   end

   // Request multiplexer: fields only matter while man_vld is high.
   always_comb begin : req_mux
      man_wen = 1'b0;
      man_ben = '0;
      man_adr = '0;
      man_wdt = '0;
      for (int i = 0; i < PN; i++) begin
         if (gnt == c_IW'(i)) begin
            man_wen = sub_wen[i];
            man_ben = sub_ben[i*BW +: BW];
            man_adr = sub_adr[i*AW +: AW];
            man_wdt = sub_wdt[i*DW +: DW];
         end
      end
   end

   assign man_vld = sub_vld[gnt];
   assign man_trn = man_vld & man_rdy;

   always_comb begin : next_state
      // Lock is set by a stall and naturally released by the transfer.
      lock_d = man_vld & ~man_rdy;
      lidx_d = gnt;
      ptr_d  = man_trn ? gnt : ptr_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q  <= c_IW'(PN-1);   // port 0 is searched first after reset
         lock_q <= 1'b0;
         lidx_q <= '0;
      end else begin
         ptr_q  <= ptr_d;
         lock_q <= lock_d;
         lidx_q <= lidx_d;
      end
   end

   // Response ownership: which port the response arriving now belongs to.
   generate
      if (DLY == 0) begin : g_rsp_comb
         assign rv   = man_trn;
         assign rsel = gnt;
      end else begin : g_rsp_pipe
         logic [DLY-1:0]  rv_q, rv_d;
         logic [c_IW-1:0] rsel_q [DLY];
         logic [c_IW-1:0] rsel_d [DLY];

         always_comb begin
            rv_d[0]   = man_trn;
            rsel_d[0] = gnt;
            for (int s = 1; s < DLY; s++) begin
               rv_d[s]   = rv_q[s-1];
               rsel_d[s] = rsel_q[s-1];
            end
         end

         always_ff @(posedge clk) begin
            if (rst) begin
               rv_q <= '0;
               for (int s = 0; s < DLY; s++) rsel_q[s] <= '0;
            end else begin
               rv_q <= rv_d;
               for (int s = 0; s < DLY; s++) rsel_q[s] <= rsel_d[s];
            end
         end

         assign rv   = rv_q[DLY-1];
         assign rsel = rsel_q[DLY-1];
      end
   endgenerate

   generate
      for (genvar i = 0; i < PN; i++) begin : g_port
         assign sub_rdy[i]          = man_trn & (gnt == c_IW'(i));
         assign sub_err[i]          = man_err & rv & (rsel == c_IW'(i));
         assign sub_rdt[i*DW +: DW] = man_rdt;
      end
   endgenerate

endmodule
`default_nettype wire

// File: tb/tb_tcb_arb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tcb_arb
//  Purpose  : Self-checking bench for tcb_arb with PN=4. Two instances share
//             the same stimulus: DLY=1 (d1) and DLY=2 (d2). A behavioural
//             model (last-served index, stalled index, response-owner queues)
//             supplies expected values.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_tcb_arb;

   localparam int PN = 4;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int BW = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [PN-1:0]    sub_vld, sub_wen;
   logic [PN*BW-1:0] sub_ben;
   logic [PN*AW-1:0] sub_adr;
   logic [PN*DW-1:0] sub_wdt;
   logic [DW-1:0]    man_rdt;
   logic             man_err, man_rdy;

   logic [PN*DW-1:0] d1_sub_rdt, d2_sub_rdt;
   logic [PN-1:0]    d1_sub_err, d2_sub_err, d1_sub_rdy, d2_sub_rdy;
   logic             d1_man_vld, d2_man_vld, d1_man_wen, d2_man_wen;
   logic [BW-1:0]    d1_man_ben, d2_man_ben;
   logic [AW-1:0]    d1_man_adr, d2_man_adr;
   logic [DW-1:0]    d1_man_wdt, d2_man_wdt;

   tcb_arb #(.AW(AW), .DW(DW), .BW(BW), .PN(PN), .DLY(1)) d1 (
      .clk(clk), .rst(rst),
      .sub_vld(sub_vld), .sub_wen(sub_wen), .sub_ben(sub_ben),
      .sub_adr(sub_adr), .sub_wdt(sub_wdt),
      .sub_rdt(d1_sub_rdt), .sub_err(d1_sub_err), .sub_rdy(d1_sub_rdy),
      .man_vld(d1_man_vld), .man_wen(d1_man_wen), .man_ben(d1_man_ben),
      .man_adr(d1_man_adr), .man_wdt(d1_man_wdt),
      .man_rdt(man_rdt), .man_err(man_err), .man_rdy(man_rdy)
   );

   tcb_arb #(.AW(AW), .DW(DW), .BW(BW), .PN(PN), .DLY(2)) d2 (
      .clk(clk), .rst(rst),
      .sub_vld(sub_vld), .sub_wen(sub_wen), .sub_ben(sub_ben),
      .sub_adr(sub_adr), .sub_wdt(sub_wdt),
      .sub_rdt(d2_sub_rdt), .sub_err(d2_sub_err), .sub_rdy(d2_sub_rdy),
      .man_vld(d2_man_vld), .man_wen(d2_man_wen), .man_ben(d2_man_ben),
      .man_adr(d2_man_adr), .man_wdt(d2_man_wdt),
      .man_rdt(man_rdt), .man_err(man_err), .man_rdy(man_rdy)
   );

   int tests_run    = 0;
   int tests_failed = 0;

   // ---------------- behavioural model ----------------
   int          m_last;   // port served by the most recent transfer
   int          m_stall;  // port whose request is waiting, -1 if none
   int          m_g;      // port expected to own the bus this cycle
   bit          m_trn;
   int          q1[$];    // response owners, oldest first, depth 1
   int          q2[$];    // response owners, oldest first, depth 2
   logic        exp_vld;
   logic [PN-1:0] exp_rdy, exp_err1, exp_err2;

   function automatic logic [PN-1:0] onehot(input int i);
      logic [PN-1:0] v;
      v = '0;
      if (i >= 0) v[i] = 1'b1;
      return v;
   endfunction

   task automatic model_eval();
      m_g = -1;
      if (m_stall >= 0) m_g = m_stall;
      else
         for (int k = 1; k <= PN; k++) begin
            int p;
            p = (m_last + k) % PN;
            if (m_g < 0 && sub_vld[p]) m_g = p;
         end
      exp_vld  = (m_g >= 0);
      m_trn    = exp_vld && man_rdy;
      exp_rdy  = m_trn ? onehot(m_g) : '0;
      exp_err1 = man_err ? onehot(q1[0]) : '0;
      exp_err2 = man_err ? onehot(q2[0]) : '0;
   endtask

   task automatic model_commit();
      if (rst) begin
         m_last  = PN-1;
         m_stall = -1;
         q1 = '{-1};
         q2 = '{-1, -1};
      end else begin
         m_stall = (m_g >= 0 && !m_trn) ? m_g : -1;
         if (m_trn) m_last = m_g;
         q1.push_back(m_trn ? m_g : -1); void'(q1.pop_front());
         q2.push_back(m_trn ? m_g : -1); void'(q2.pop_front());
      end
   endtask

   // ---------------- stimulus helpers ----------------
   task automatic settle();
      @(negedge clk);
      model_eval();
   endtask

   task automatic advance();
      @(posedge clk);
      model_commit();
      #1;
   endtask

   task automatic clear_inputs();
      sub_vld = '0; sub_wen = '0; sub_ben = '0; sub_adr = '0; sub_wdt = '0;
      man_rdt = '0; man_err = 1'b0; man_rdy = 1'b1;
   endtask

   task automatic set_req(input int i, input bit v, input logic [31:0] a);
      sub_vld[i]            = v;
      sub_adr[i*AW +: AW]   = a;
      sub_wdt[i*DW +: DW]   = a ^ 32'hA5A5_0000;
      sub_wen[i]            = a[0];
      sub_ben[i*BW +: BW]   = a[7:4];
   endtask

   task automatic do_reset(input int n);
      rst = 1'b1;
      clear_inputs();
      repeat (n) begin settle(); advance(); end
      rst = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b1;
      clear_inputs();
      for (int i = 0; i < PN; i++) set_req(i, 1'b1, 32'h10 * (i + 1));
      man_err = 1'b1;
      for (int c = 0; c < 3; c++) begin
         settle();
         if (c > 0) begin
            tests_run++;
            if (d1_man_vld !== 1'b1) begin
               tests_failed++;
               $display("FAIL rst_man_vld got=%b exp=1", d1_man_vld);
            end
            tests_run++;
            if (d1_sub_rdy !== 4'b0001) begin
               tests_failed++;
               $display("FAIL rst_rdy got=%b exp=0001", d1_sub_rdy);
            end
            tests_run++;
            if (d1_sub_err !== 4'b0000 || d2_sub_err !== 4'b0000) begin
               tests_failed++;
               $display("FAIL rst_err got=%b/%b exp=0000", d1_sub_err, d2_sub_err);
            end
         end
         advance();
      end
      rst = 1'b0;
      man_err = 1'b0;
   endtask

   task automatic test_rotation();
      do_reset(1);
      for (int i = 0; i < PN; i++) set_req(i, 1'b1, 32'h1000 + 32'h40 * i);
      man_rdy = 1'b1;
      for (int c = 0; c < 8; c++) begin
         settle();
         tests_run++;
         if (d1_sub_rdy !== onehot(c % PN) || d1_sub_rdy !== exp_rdy) begin
            tests_failed++;
            $display("FAIL rot_rdy cyc=%0d got=%b exp=%b", c, d1_sub_rdy, onehot(c % PN));
         end
         tests_run++;
         if (d1_man_adr !== 32'h1000 + 32'h40 * (c % PN)) begin
            tests_failed++;
            $display("FAIL rot_adr cyc=%0d got=%h exp=%h", c, d1_man_adr,
                     32'h1000 + 32'h40 * (c % PN));
         end
         advance();
      end
   endtask

   task automatic test_stall();
      logic [PN-1:0] t_rdy [5];
      logic [31:0]   t_adr [5];
      bit            t_in  [5];
      t_rdy = '{4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0010};
      t_adr = '{32'h100, 32'h100, 32'h100, 32'h100, 32'h200};
      t_in  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      do_reset(1);
      for (int c = 0; c < 5; c++) begin
         if (c == 0) set_req(2, 1'b1, 32'h100);
         if (c == 1) set_req(1, 1'b1, 32'h200);
         if (c == 4) set_req(2, 1'b0, 32'h100);
         man_rdy = t_in[c];
         settle();
         tests_run++;
         if (d1_sub_rdy !== t_rdy[c] || d1_man_vld !== 1'b1) begin
            tests_failed++;
            $display("FAIL stall_rdy cyc=%0d got=%b vld=%b exp=%b vld=1",
                     c, d1_sub_rdy, d1_man_vld, t_rdy[c]);
         end
         tests_run++;
         if (d1_man_adr !== t_adr[c]) begin
            tests_failed++;
            $display("FAIL stall_adr cyc=%0d got=%h exp=%h", c, d1_man_adr, t_adr[c]);
         end
         advance();
      end
   endtask

   task automatic test_err_route();
      do_reset(1);
      set_req(1, 1'b1, 32'h55);
      settle();
      tests_run++;
      if (d1_sub_rdy !== 4'b0010) begin
         tests_failed++;
         $display("FAIL err_trn got=%b exp=0010", d1_sub_rdy);
      end
      advance();
      set_req(1, 1'b0, 32'h55);
      man_err = 1'b1;
      settle();
      tests_run++;
      if (d1_sub_err !== 4'b0010 || d2_sub_err !== 4'b0000) begin
         tests_failed++;
         $display("FAIL err_d1 got=%b/%b exp=0010/0000", d1_sub_err, d2_sub_err);
      end
      advance();
      settle();
      tests_run++;
      if (d2_sub_err !== 4'b0010 || d1_sub_err !== 4'b0000) begin
         tests_failed++;
         $display("FAIL err_d2 got=%b/%b exp=0000/0010", d1_sub_err, d2_sub_err);
      end
      advance();
      man_err = 1'b0;
   endtask

   task automatic test_back_to_back();
      int seq [3];
      seq = '{3, 0, 3};
      do_reset(1);
      man_err = 1'b1;
      for (int c = 0; c < 5; c++) begin
         sub_vld = '0;
         if (c < 3) set_req(seq[c], 1'b1, 32'h700 + c);
         settle();
         if (c < 3) begin
            tests_run++;
            if (d1_sub_rdy !== onehot(seq[c])) begin
               tests_failed++;
               $display("FAIL b2b_rdy cyc=%0d got=%b exp=%b", c, d1_sub_rdy, onehot(seq[c]));
            end
         end
         if (c >= 2) begin
            tests_run++;
            if (d2_sub_err !== onehot(seq[c-2])) begin
               tests_failed++;
               $display("FAIL b2b_err2 cyc=%0d got=%b exp=%b", c, d2_sub_err, onehot(seq[c-2]));
            end
         end
         if (c >= 1 && c <= 3) begin
            tests_run++;
            if (d1_sub_err !== onehot(seq[c-1])) begin
               tests_failed++;
               $display("FAIL b2b_err1 cyc=%0d got=%b exp=%b", c, d1_sub_err, onehot(seq[c-1]));
            end
         end
         advance();
      end
      man_err = 1'b0;
   endtask

   task automatic test_reset_mid_stall();
      do_reset(1);
      man_rdy = 1'b0;
      set_req(2, 1'b1, 32'h300);
      for (int c = 0; c < 2; c++) begin
         if (c == 1) set_req(0, 1'b1, 32'h30);
         settle();
         tests_run++;
         if (d1_sub_rdy !== 4'b0000 || d1_man_adr !== 32'h300) begin
            tests_failed++;
            $display("FAIL mid_stall cyc=%0d rdy=%b adr=%h exp rdy=0000 adr=300",
                     c, d1_sub_rdy, d1_man_adr);
         end
         advance();
      end
      rst = 1'b1;
      settle();
      advance();
      rst = 1'b0;
      man_rdy = 1'b1;
      settle();
      tests_run++;
      if (d1_sub_rdy !== 4'b0001 || d1_man_adr !== 32'h30) begin
         tests_failed++;
         $display("FAIL mid_rst_first rdy=%b adr=%h exp rdy=0001 adr=30", d1_sub_rdy, d1_man_adr);
      end
      advance();
      set_req(0, 1'b0, 32'h30);
      settle();
      tests_run++;
      if (d1_sub_rdy !== 4'b0100) begin
         tests_failed++;
         $display("FAIL mid_rst_second got=%b exp=0100", d1_sub_rdy);
      end
      advance();
   endtask

   task automatic test_wrap();
      do_reset(1);
      set_req(3, 1'b1, 32'h3C);
      settle();
      tests_run++;
      if (d1_sub_rdy !== 4'b1000 || d1_man_vld !== 1'b1 || d1_man_adr !== 32'h3C) begin
         tests_failed++;
         $display("FAIL wrap rdy=%b vld=%b adr=%h exp rdy=1000 vld=1 adr=3c",
                  d1_sub_rdy, d1_man_vld, d1_man_adr);
      end
      advance();
   endtask

   task automatic test_random();
      int pr;
      do_reset(1);
      for (int c = 0; c < 400; c++) begin
         rst = ($urandom_range(0, 63) == 0);
         for (int i = 0; i < PN; i++)
            if (i != m_stall) set_req(i, ($urandom_range(0, 2) != 0), $urandom);
         man_rdy = ($urandom_range(0, 3) != 0);
         man_err = $urandom_range(0, 1);
         man_rdt = $urandom;
         settle();
         tests_run++;
         if (d1_man_vld !== exp_vld || d1_sub_rdy !== exp_rdy) begin
            tests_failed++;
            $display("FAIL rnd_arb cyc=%0d vld=%b rdy=%b exp vld=%b rdy=%b",
                     c, d1_man_vld, d1_sub_rdy, exp_vld, exp_rdy);
         end
         if (exp_vld) begin
            tests_run++;
            if (d1_man_adr !== sub_adr[m_g*AW +: AW] || d1_man_wdt !== sub_wdt[m_g*DW +: DW] ||
                d1_man_wen !== sub_wen[m_g] || d1_man_ben !== sub_ben[m_g*BW +: BW]) begin
               tests_failed++;
               $display("FAIL rnd_fields cyc=%0d adr=%h exp=%h port=%0d",
                        c, d1_man_adr, sub_adr[m_g*AW +: AW], m_g);
            end
         end
         tests_run++;
         if (d1_sub_err !== exp_err1 || d2_sub_err !== exp_err2) begin
            tests_failed++;
            $display("FAIL rnd_err cyc=%0d got=%b/%b exp=%b/%b",
                     c, d1_sub_err, d2_sub_err, exp_err1, exp_err2);
         end
         pr = $urandom_range(0, PN-1);
         tests_run++;
         if (d1_sub_rdt[pr*DW +: DW] !== man_rdt || d2_sub_rdt[pr*DW +: DW] !== man_rdt) begin
            tests_failed++;
            $display("FAIL rnd_rdt cyc=%0d port=%0d got=%h exp=%h",
                     c, pr, d1_sub_rdt[pr*DW +: DW], man_rdt);
         end
         advance();
      end
      rst = 1'b0;
   endtask

   initial begin
      m_last  = PN-1;
      m_stall = -1;
      q1 = '{-1};
      q2 = '{-1, -1};
      test_reset();
      test_rotation();
      test_stall();
      test_err_route();
      test_back_to_back();
      test_reset_mid_stall();
      test_wrap();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1);
   end

endmodule
`default_nettype wire
